matmul_gesture_classifier: RTL and testbench

Frame-level gesture classifier that drives the weight ROM read port (`gesture`/`pixel_addr` → signed `weight`). It buffers one 8×8 pixel frame from an upstream valid/ready stream, then walks the ROM once per gesture (UP=0, DOWN=1, LEFT=2, RIGHT=3). For each gesture it computes the dot product of pixels and weights, and emits the argmax gesture plus its score on a downstream valid/ready port.

---
 rtl/matmul_gesture_classifier.sv | 178 +++++++++++++++++
 tb/tb_matmul_gesture_classifier.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_gesture_classifier.sv
// rtl/matmul_gesture_classifier.sv - 8x8 frame gesture classifier (dot product against ROM weights, argmax)
//
// Buffers one 64-pixel frame, walks the weight ROM once per gesture
// (UP=0, DOWN=1, LEFT=2, RIGHT=3), accumulates pixel*weight and reports the
// best-scoring gesture. Ties go to the lowest gesture index.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   pixel_i/valid_i/ready_o   upstream pixel stream, raster order
//   gesture_o/pixel_addr_o    weight ROM read address (0 outside COMPUTE)
//   weight_i                  signed ROM weight, combinational from the address
//   class_o/score_o/valid_o   result, held while valid_o is high
//   ready_i                   downstream accepts result
//
// Build option: MATMUL_CLASSIFIER_WREG_EN registers weight and pixel one
// stage ahead of the multiply-accumulate (COMPUTE takes one extra cycle).
module matmul_gesture_classifier #(
  parameter int PIXEL_WIDTH_P   = 8,
  parameter int COUNTER_WIDTH_P = 8,
  parameter int ACC_WIDTH_P     = 20
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [PIXEL_WIDTH_P-1:0]      pixel_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [1:0]                    gesture_o,
  output logic [5:0]                    pixel_addr_o,
  input  logic signed [COUNTER_WIDTH_P-1:0] weight_i,
  output logic [1:0]                    class_o,
  output logic signed [ACC_WIDTH_P-1:0] score_o,
  output logic                          valid_o,
  input  logic                          ready_i
);

  typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_e;

  state_e state_q, state_d;

  logic [PIXEL_WIDTH_P-1:0] pix_buf_q [64];
  logic [5:0] wr_cnt_q;
  logic [5:0] a_q;
  logic [1:0] g_q;
  logic signed [ACC_WIDTH_P-1:0] acc_q, best_score_q;
  logic [1:0] best_class_q;

  logic accept;
  logic issue_en;

  // Operands presented to the multiply-accumulate stage.
  logic                              mac_en;
  logic                              mac_last;
  logic [1:0]                        mac_g;
  logic [PIXEL_WIDTH_P-1:0]          mac_pix;
  logic signed [COUNTER_WIDTH_P-1:0] mac_w;

  logic signed [ACC_WIDTH_P-1:0] pix_ext, w_ext, prod, sum;
  logic frame_end;

  assign accept = valid_i && ready_o;

`ifdef MATMUL_CLASSIFIER_WREG_EN
  // Addresses are issued one cycle ahead of the MAC; issue stops after the
  // last address of gesture 3 while the final product drains.
  logic                              issue_done_q;
  logic                              mac_en_q, mac_last_q;
  logic [1:0]                        mac_g_q;
  logic [PIXEL_WIDTH_P-1:0]          mac_pix_q;
  logic signed [COUNTER_WIDTH_P-1:0] mac_w_q;

  assign issue_en = (state_q == COMPUTE) && !issue_done_q;
  assign mac_en   = mac_en_q;
  assign mac_last = mac_last_q;
  assign mac_g    = mac_g_q;
  assign mac_pix  = mac_pix_q;
  assign mac_w    = mac_w_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      issue_done_q <= 1'b0;
      mac_en_q     <= 1'b0;
      mac_last_q   <= 1'b0;
      mac_g_q      <= 2'd0;
      mac_pix_q    <= '0;
      mac_w_q      <= '0;
    end else begin
      if (state_q == LOAD) begin
        issue_done_q <= 1'b0;
      end else if (issue_en && a_q == 6'd63 && g_q == 2'd3) begin
        issue_done_q <= 1'b1;
      end
      mac_en_q   <= issue_en;
      mac_last_q <= (a_q == 6'd63);
      mac_g_q    <= g_q;
      mac_pix_q  <= pix_buf_q[a_q];
      mac_w_q    <= weight_i;
    end
  end
`else
  assign issue_en = (state_q == COMPUTE);
  assign mac_en   = issue_en;
  assign mac_last = (a_q == 6'd63);
  assign mac_g    = g_q;
  assign mac_pix  = pix_buf_q[a_q];
  assign mac_w    = weight_i;
`endif

  // Unsigned pixel times signed weight, evaluated and wrapped at accumulator width.
  assign pix_ext   = {{(ACC_WIDTH_P-PIXEL_WIDTH_P){1'b0}}, mac_pix};
  assign w_ext     = {{(ACC_WIDTH_P-COUNTER_WIDTH_P){mac_w[COUNTER_WIDTH_P-1]}}, mac_w};
  assign prod      = pix_ext * w_ext;
  assign sum       = acc_q + prod;
  assign frame_end = mac_en && mac_last && (mac_g == 2'd3);

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (accept && wr_cnt_q == 6'd63) state_d = COMPUTE;
      COMPUTE: if (frame_end) state_d = DONE;
      DONE:    if (ready_i) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= LOAD;
    else         state_q <= state_d;
  end

  // Frame buffer is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (accept) pix_buf_q[wr_cnt_q] <= pixel_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_cnt_q     <= 6'd0;
      a_q          <= 6'd0;
      g_q          <= 2'd0;
      acc_q        <= '0;
      best_score_q <= '0;
      best_class_q <= 2'd0;
    end else begin
      if (accept) wr_cnt_q <= wr_cnt_q + 6'd1;
      if (state_q == DONE && ready_i) wr_cnt_q <= 6'd0;

      if (state_q == LOAD) begin
        a_q   <= 6'd0;
        g_q   <= 2'd0;
        acc_q <= '0;
      end else if (issue_en) begin
        a_q <= a_q + 6'd1;
        if (a_q == 6'd63) g_q <= g_q + 2'd1;
      end

      if (mac_en) begin
        if (mac_last) begin
          acc_q <= '0;
          // Gesture 0 seeds the best; later gestures must strictly beat it.
          if (mac_g == 2'd0 || sum > best_score_q) begin
            best_score_q <= sum;
            best_class_q <= mac_g;
          end
        end else begin
          acc_q <= sum;
        end
      end
    end
  end

  assign ready_o      = (state_q == LOAD) && !reset_i;
  assign valid_o      = (state_q == DONE) && !reset_i;
  assign class_o      = valid_o ? best_class_q : 2'd0;
  assign score_o      = valid_o ? best_score_q : '0;
  assign gesture_o    = (issue_en && !reset_i) ? g_q : 2'd0;
  assign pixel_addr_o = (issue_en && !reset_i) ? a_q : 6'd0;

endmodule

// File: tb/tb_matmul_gesture_classifier.sv
// tb/tb_matmul_gesture_classifier.sv - self-checking bench for matmul_gesture_classifier
//
// Models the weight ROM: each gesture weighs its own half of the frame +2
// and the opposite half -1 (UP=rows 0-3, DOWN=rows 4-7, LEFT=cols 0-3,
// RIGHT=cols 4-7). Expected results are queued when a frame is sent and
// popped when the DUT presents valid_o.
module tb_matmul_gesture_classifier;

  localparam int ACC_W = 20;
`ifdef MATMUL_CLASSIFIER_WREG_EN
  localparam int LAT = 258;
`else
  localparam int LAT = 257;
`endif

  typedef struct {
    logic [1:0]              cls;
    logic signed [ACC_W-1:0] score;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic [7:0] pixel_i = 8'd0;
  logic valid_i = 1'b0;
  logic ready_o;
  logic [1:0] gesture_o;
  logic [5:0] pixel_addr_o;
  logic signed [7:0] weight_i;
  logic [1:0] class_o;
  logic signed [ACC_W-1:0] score_o;
  logic valid_o;
  logic ready_i = 1'b0;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];
  logic [7:0] frame [64];

  always #5 clk = ~clk;

  matmul_gesture_classifier dut (
    .clk_i(clk), .reset_i(reset_i), .pixel_i(pixel_i), .valid_i(valid_i),
    .ready_o(ready_o), .gesture_o(gesture_o), .pixel_addr_o(pixel_addr_o),
    .weight_i(weight_i), .class_o(class_o), .score_o(score_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  function automatic logic signed [7:0] rom_w(input logic [1:0] g, input logic [5:0] addr);
    logic own;
    case (g)
      2'd0:    own = (addr[5:3] < 3'd4);
      2'd1:    own = (addr[5:3] >= 3'd4);
      2'd2:    own = (addr[2:0] < 3'd4);
      default: own = (addr[2:0] >= 3'd4);
    endcase
    return own ? 8'sd2 : -8'sd1;
  endfunction

  always_comb weight_i = rom_w(gesture_o, pixel_addr_o);

  function automatic exp_t model();
    exp_t r;
    int best, s;
    best = 0;
    r.cls = 2'd0;
    for (int g = 0; g < 4; g++) begin
      s = 0;
      for (int i = 0; i < 64; i++) s += int'(frame[i]) * int'(rom_w(2'(g), 6'(i)));
      if (g == 0 || s > best) begin
        best = s;
        r.cls = 2'(g);
      end
    end
    r.score = ACC_W'(best);
    return r;
  endfunction

  // kind: 0 UP, 1 RIGHT, 2 zero, 3 bottom-left, 4 random
  task automatic build_frame(input int kind);
    for (int i = 0; i < 64; i++) begin
      case (kind)
        0:       frame[i] = (i / 8 < 4) ? 8'd255 : 8'd0;
        1:       frame[i] = (i % 8 >= 4) ? 8'd10 : 8'd0;
        3:       frame[i] = (i / 8 >= 4 && i % 8 < 4) ? 8'd255 : 8'd0;
        4:       frame[i] = 8'($urandom_range(0, 255));
        default: frame[i] = 8'd0;
      endcase
    end
  endtask

  // Returns just after the posedge that accepts the last pixel.
  task automatic send_frame(input bit gaps);
    int w;
    for (int i = 0; i < 64; i++) begin
      if (gaps) begin
        @(negedge clk);
        valid_i = 1'b0;
        pixel_i = 8'hA5;
        @(posedge clk);
      end
      @(negedge clk);
      valid_i = 1'b1;
      pixel_i = frame[i];
      w = 0;
      while (!ready_o && w < 1000) begin
        @(posedge clk);
        @(negedge clk);
        w++;
      end
      if (w >= 1000) begin
        errors++;
        checks++;
        $display("FAIL send_timeout: ready_o stayed %0b, required 1", ready_o);
      end
      @(posedge clk);
    end
    #1 valid_i = 1'b0;
  endtask

  // Waits for valid_o; cyc is the cycle index relative to the last accept.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    @(negedge clk);
    while (!valid_o && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    ready_i = 1'b1;
    @(posedge clk);
    #1 ready_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", ready_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid_o); end
    checks++; if (class_o !== 2'd0 || score_o !== '0) begin errors++; $display("FAIL reset_result: got %0d/%0d want 0/0", class_o, score_o); end
    checks++; if (gesture_o !== 2'd0 || pixel_addr_o !== 6'd0) begin errors++; $display("FAIL reset_addr: got %0d/%0d want 0/0", gesture_o, pixel_addr_o); end
    @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", ready_o); end
  endtask

  // Send a frame, check latency (optional) and the popped expectation.
  task automatic run_frame(input string name, input bit gaps, input bit chk_lat);
    int cyc;
    exp_t e;
    send_frame(gaps);
    wait_valid(cyc);
    checks++; if (!valid_o) begin errors++; $display("FAIL %s_timeout: valid_o %0b want 1", name, valid_o); end
    if (chk_lat) begin
      checks++; if (cyc != LAT) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, LAT); end
    end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL %s_scoreboard: queue empty, got %0d/%0d", name, class_o, score_o);
    end else begin
      e = sb.pop_front();
      if (class_o !== e.cls || score_o !== e.score) begin
        errors++; $display("FAIL %s_result: got class %0d score %0d want class %0d score %0d", name, class_o, score_o, e.cls, e.score);
      end
    end
    handshake();
    @(negedge clk);
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL %s_after_hs: ready %0b valid %0b want 1 0", name, ready_o, valid_o); end
  endtask

  task automatic test_up_frame();
    build_frame(0);
    sb.push_back('{cls: 2'd0, score: 20'sd16320});
    run_frame("up", 1'b0, 1'b1);
  endtask

  task automatic test_right_frame();
    build_frame(1);
    sb.push_back('{cls: 2'd3, score: 20'sd640});
    run_frame("right", 1'b0, 1'b1);
  endtask

  task automatic test_ties();
    build_frame(2);
    sb.push_back('{cls: 2'd0, score: 20'sd0});
    run_frame("tie_zero", 1'b0, 1'b0);
    build_frame(3);
    sb.push_back('{cls: 2'd1, score: 20'sd8160});
    run_frame("tie_down_left", 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    int cyc;
    exp_t e;
    build_frame(0);
    sb.push_back('{cls: 2'd0, score: 20'sd16320});
    send_frame(1'b0);
    wait_valid(cyc);
    e = sb.pop_front();
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || class_o !== e.cls || score_o !== e.score) begin
        errors++;
        $display("FAIL bp_hold%0d: valid %0b ready %0b class %0d score %0d want 1 0 %0d %0d", k, valid_o, ready_o, class_o, score_o, e.cls, e.score);
      end
      @(negedge clk);
    end
    handshake();
    @(negedge clk);
    checks++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin errors++; $display("FAIL bp_release: ready %0b valid %0b want 1 0", ready_o, valid_o); end
  endtask

  task automatic test_gaps();
    build_frame(3);
    sb.push_back('{cls: 2'd1, score: 20'sd8160});
    run_frame("gaps_bl", 1'b1, 1'b1);
    build_frame(0);
    sb.push_back('{cls: 2'd0, score: 20'sd16320});
    run_frame("gaps_up", 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_compute();
    build_frame(0);
    send_frame(1'b0);
    // Cycle T+95 is g=1, a=30 on the unregistered timing.
    repeat (95) @(negedge clk);
    checks++; if (gesture_o !== 2'd1) begin errors++; $display("FAIL midrst_gesture: got %0d want 1", gesture_o); end
    reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || class_o !== 2'd0 || score_o !== '0) begin
      errors++;
      $display("FAIL midrst_state: ready %0b valid %0b class %0d score %0d want 1 0 0 0", ready_o, valid_o, class_o, score_o);
    end
    sb.push_back('{cls: 2'd0, score: 20'sd16320});
    run_frame("midrst_up", 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      build_frame(4);
      sb.push_back(model());
      run_frame("b2b_random", 1'b0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_up_frame();
    test_right_frame();
    test_ties();
    test_backpressure();
    test_gaps();
    test_reset_mid_compute();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
